// File: rtl/ldm_expander.sv
// Pre-decode stage: splits ARM LDM/STM into single LDR/STR words (+ optional base writeback).
// Writeback generation is built only when LDM_EXPANDER_WB_EN is defined.
module ldm_expander (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_code,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_code,
   output logic        out_last,
   output logic        out_user,
   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      XFER = 2'd1
`ifdef LDM_EXPANDER_WB_EN
      , WB = 2'd2
`endif
   } state_t;

   state_t             state;
   logic [3:0]         cond, rn;
   logic               l, s, wb_req, rn_pend;
   logic [15:0]        list, mask;
   logic signed [7:0]  base;
`ifdef LDM_EXPANDER_WB_EN
   logic               u;
   logic [4:0]         n;
`endif

   function automatic logic [4:0] popcnt(input logic [15:0] v);
      popcnt = 5'd0;
      for (int i = 0; i < 16; i++) popcnt = popcnt + {4'd0, v[i]};
   endfunction

   function automatic logic [3:0] low_idx(input logic [15:0] v);
      low_idx = 4'd0;
      for (int i = 15; i >= 0; i--) if (v[i]) low_idx = 4'(i);
   endfunction

   // Offset of a register is fixed by its ascending position in the full list,
   // even when its transfer is reordered.
   function automatic logic [31:0] xfer_word(input logic [3:0] c, input logic ld,
                                             input logic [3:0] b_rn, input logic [15:0] lst,
                                             input logic signed [7:0] b, input logic [3:0] rd);
      logic [4:0]        pos;
      logic signed [7:0] off;
      logic [7:0]        mag;
      pos = popcnt(lst & ((16'h1 << rd) - 16'h1));
      off = b + $signed({1'b0, pos, 2'b00});
      mag = off[7] ? 8'(-off) : 8'(off);
      return {c, 2'b01, 1'b0, 1'b1, ~off[7], 1'b0, 1'b0, ld, b_rn, rd, 4'h0, mag};
   endfunction

   logic              in_blk, in_l, in_rn_last, in_rn_pend, in_only, in_wb;
   logic [3:0]        in_rn, in_first;
   logic [15:0]       in_list, in_mask0, in_rest;
   logic [4:0]        in_n;
   logic [7:0]        n4;
   logic signed [7:0] in_base;

   always_comb begin
      in_blk     = (in_code[27:25] == 3'b100);
      in_list    = in_code[15:0];
      in_rn      = in_code[19:16];
      in_l       = in_code[20];
      in_n       = popcnt(in_list);
      n4         = {1'b0, in_n, 2'b00};
      in_rn_last = in_l & in_list[in_rn];
      in_mask0   = in_rn_last ? (in_list & ~(16'h1 << in_rn)) : in_list;
      in_first   = (in_mask0 != 16'd0) ? low_idx(in_mask0) : in_rn;
      in_rest    = in_mask0 & ~(16'h1 << in_first);
      in_rn_pend = in_rn_last && (in_mask0 != 16'd0);
      in_only    = (in_rest == 16'd0) && !in_rn_pend;
      case (in_code[24:23])
         2'b01:   in_base = 8'sd0;
         2'b11:   in_base = 8'sd4;
         2'b00:   in_base = $signed(8'd4 - n4);
         default: in_base = $signed(8'd0 - n4);
      endcase
`ifdef LDM_EXPANDER_WB_EN
      in_wb = in_code[21] & ~in_rn_last;
`else
      in_wb = in_code[21] & 1'b0;
`endif
   end

   logic        more, cur_pend, cur_only;
   logic [3:0]  cur_first;
   logic [15:0] cur_rest;

   always_comb begin
      more      = (mask != 16'd0) || rn_pend;
      cur_first = (mask != 16'd0) ? low_idx(mask) : rn;
      cur_rest  = mask & ~(16'h1 << cur_first);
      cur_pend  = rn_pend && (mask != 16'd0);
      cur_only  = (cur_rest == 16'd0) && !cur_pend;
   end

   assign in_ready = !rst && !flush && (state == IDLE) && (!out_valid || out_ready);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         out_valid <= 1'b0;
         out_code  <= 32'd0;
         out_last  <= 1'b0;
         out_user  <= 1'b0;
         busy      <= 1'b0;
         cond      <= 4'd0;
         rn        <= 4'd0;
         l         <= 1'b0;
         s         <= 1'b0;
         wb_req    <= 1'b0;
         rn_pend   <= 1'b0;
         list      <= 16'd0;
         mask      <= 16'd0;
         base      <= 8'sd0;
`ifdef LDM_EXPANDER_WB_EN
         u         <= 1'b0;
         n         <= 5'd0;
`endif
      end else if (flush) begin
         state     <= IDLE;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  out_valid <= 1'b1;
                  out_user  <= 1'b0;
                  out_last  <= 1'b1;
                  if (in_blk && in_n != 5'd0) begin
                     out_code <= xfer_word(in_code[31:28], in_l, in_rn, in_list, in_base, in_first);
                     out_last <= in_only && !in_wb;
                     out_user <= in_code[22];
                     cond     <= in_code[31:28];
                     rn       <= in_rn;
                     l        <= in_l;
                     s        <= in_code[22];
                     wb_req   <= in_wb;
                     list     <= in_list;
                     base     <= in_base;
                     mask     <= in_rest;
                     rn_pend  <= in_rn_pend;
`ifdef LDM_EXPANDER_WB_EN
                     u        <= in_code[23];
                     n        <= in_n;
`endif
                     state    <= XFER;
                     busy     <= 1'b1;
                  end else if (in_blk) begin
                     out_code <= {in_code[31:28], 28'h1A00000};
                  end else begin
                     out_code <= in_code;
                  end
               end else if (out_ready) begin
                  out_valid <= 1'b0;
               end
            end
            XFER: begin
               if (out_ready) begin
                  if (more) begin
                     out_code <= xfer_word(cond, l, rn, list, base, cur_first);
                     out_last <= cur_only && !wb_req;
                     mask     <= cur_rest;
                     rn_pend  <= cur_pend;
                  end
`ifdef LDM_EXPANDER_WB_EN
                  else if (wb_req) begin
                     out_code <= {cond, 2'b00, 1'b1, (u ? 4'b0100 : 4'b0010), 1'b0,
                                  rn, rn, 4'h0, 1'b0, n, 2'b00};
                     out_last <= 1'b1;
                     out_user <= s;
                     state    <= WB;
                  end
`endif
                  else begin
                     out_valid <= 1'b0;
                     state     <= IDLE;
                     busy      <= 1'b0;
                  end
               end
            end
`ifdef LDM_EXPANDER_WB_EN
            WB: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
                  busy      <= 1'b0;
               end
            end
`endif
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ldm_expander.sv
// Directed bench for ldm_expander: expected words queued at issue, popped by an output monitor.
module tb_ldm_expander;
   logic        clk = 1'b0;
   logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
   logic        out_last, out_user, busy;
   logic [31:0] in_code, out_code;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int busy_cnt = 0;
   int prev_pop = -1;
   logic gap_chk = 1'b0;
   logic [33:0] exp_q[$];

   ldm_expander dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
      .out_valid(out_valid), .out_ready(out_ready), .out_code(out_code),
      .out_last(out_last), .out_user(out_user), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   task automatic push(input logic [31:0] code, input logic last, input logic user);
      exp_q.push_back({last, user, code});
   endtask

   task automatic send(input logic [31:0] w);
      in_code  = w;
      in_valid = 1'b1;
      for (int t = 0; t < 200; t++) begin
         @(negedge clk);
         if (in_ready) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            return;
         end
      end
      checks++;
      errors++;
      $display("FAIL send_timeout word=%h", w);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      for (int t = 0; t < 100; t++) begin
         @(posedge clk);
         #1;
         if (exp_q.size() == 0 && !out_valid) return;
      end
      checks++;
      errors++;
      $display("FAIL drain_timeout pending=%0d", exp_q.size());
      exp_q.delete();
   endtask

   // Output monitor: every consumed word is compared against the head of the queue.
   always @(negedge clk) begin
      if (!rst && busy) busy_cnt++;
      if (!rst && out_valid && out_ready) begin
         logic [33:0] e;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_word got=%h last=%b user=%b", out_code, out_last, out_user);
         end else begin
            e = exp_q.pop_front();
            if ({out_last, out_user, out_code} !== e)begin
               errors++;
               $display("FAIL out_word got=%h last=%b user=%b exp=%h last=%b user=%b",
                        out_code, out_last, out_user, e[31:0], e[33], e[32]);
            end
         end
         if (gap_chk) begin
            if (prev_pop >= 0) begin
               checks++;
               if (cyc != prev_pop + 1) begin
                  errors++;
                  $display("FAIL no_bubble got_cycle=%0d exp_cycle=%0d", cyc, prev_pop + 1);
               end
            end
            prev_pop = cyc;
         end
      end
   end

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_code = 32'd0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_code", out_code, 32'd0);
      check("rst_out_last", {31'd0, out_last}, 32'd0);
      check("rst_out_user", {31'd0, out_user}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_in_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("idle_in_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;

      // LDMIA r0!,{r1,r2}
      busy_cnt = 0;
      push(32'hE5901000, 1'b0, 1'b0);
`ifdef LDM_EXPANDER_WB_EN
      push(32'hE5902004, 1'b0, 1'b0);
      push(32'hE2800008, 1'b1, 1'b0);
`else
      push(32'hE5902004, 1'b1, 1'b0);
`endif
      send(32'hE8B00006);
      drain();
`ifdef LDM_EXPANDER_WB_EN
      check("ldmia_busy_cycles", busy_cnt, 32'd3);
`else
      check("ldmia_busy_cycles", busy_cnt, 32'd2);
`endif

      // STMDB sp!,{r4,lr}
      push(32'hE50D4008, 1'b0, 1'b0);
`ifdef LDM_EXPANDER_WB_EN
      push(32'hE50DE004, 1'b0, 1'b0);
      push(32'hE24DD008, 1'b1, 1'b0);
`else
      push(32'hE50DE004, 1'b1, 1'b0);
`endif
      send(32'hE92D4010);
      drain();

      // Back-to-back pass-through words
      gap_chk = 1'b1;
      prev_pop = -1;
      for (int i = 0; i < 4; i++) begin
         push(32'hE0810002, 1'b1, 1'b0);
         send(32'hE0810002);
      end
      drain();
      gap_chk = 1'b0;

      // LDMIA r0!,{r0,r1}: base load deferred, no writeback
      push(32'hE5901004, 1'b0, 1'b0);
      push(32'hE5900000, 1'b1, 1'b0);
      send(32'hE8B00003);
      drain();

      // Back-pressure on the second word of LDMIA r0!,{r1,r2}
      push(32'hE5901000, 1'b0, 1'b0);
`ifdef LDM_EXPANDER_WB_EN
      push(32'hE5902004, 1'b0, 1'b0);
      push(32'hE2800008, 1'b1, 1'b0);
`else
      push(32'hE5902004, 1'b1, 1'b0);
`endif
      send(32'hE8B00006);
      @(posedge clk); #1;
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("stall_valid", {31'd0, out_valid}, 32'd1);
         check("stall_code", out_code, 32'hE5902004);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      drain();

      // Flush while the first word of STMDB is waiting
      out_ready = 1'b0;
      send(32'hE92D4010);
      @(negedge clk);
      check("pre_flush_code", out_code, 32'hE50D4008);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      @(negedge clk);
      check("flush_out_valid", {31'd0, out_valid}, 32'd0);
      check("flush_in_ready", {31'd0, in_ready}, 32'd1);
      check("flush_busy", {31'd0, busy}, 32'd0);
      @(posedge clk); #1;
      out_ready = 1'b1;

      // Empty list -> MOV r0,r0
      push(32'hE1A00000, 1'b1, 1'b0);
      send(32'hE8B00000);
      drain();

      // LDMIA r0,{r1,r2}^ : user-bank flag carried
      push(32'hE5901000, 1'b0, 1'b1);
      push(32'hE5902004, 1'b1, 1'b1);
      send(32'hE8D00006);
      drain();

      // LDMDA r3,{r0,r2}: negative then zero offset
      push(32'hE5130004, 1'b0, 1'b0);
      push(32'hE5932000, 1'b1, 1'b0);
      send(32'hE8130005);
      drain();

      // STMIB r1,{r5}
      push(32'hE5815004, 1'b1, 1'b0);
      send(32'hE9810020);
      drain();

      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout");
      errors++;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/ldm_expander.md
# ldm_expander

Sequential pre-decode stage that sits between instruction fetch and the ARM instruction decoder. It accepts one 32-bit ARM word at a time. Each block data transfer (LDM/STM) is re-encoded into a stream of single-register LDR/STR words, optionally followed by a base-writeback ADD/SUB word, so the downstream decoder and datapath only ever execute single transfers. All other words pass through unchanged as a single-word stream.

## Interface
- No parameters.
- clk  input  1  clock; all state on rising edge
- rst  input  1  asynchronous, active-high reset
- flush  input  1  abandon any in-progress or pending stream (branch/exception)
- in_valid  input  1  in_code valid
- in_ready  output  1  expander accepts in_code this cycle
- in_code  input  32  fetched ARM instruction word
- out_valid  output  1  out_code valid
- out_ready  input  1  decoder consumes out_code this cycle
- out_code  output  32  encoded ARM word for the decoder
- out_last  output  1  final word of the current stream
- out_user  output  1  copy of LDM/STM S bit (user-bank transfer), 0 for other words
- busy  output  1  a stream is being emitted

## Operation
- Block transfer detect: in_code[27:25]==3'b100. Fields: cond[31:28], P[24], U[23], S[22], W[21], L[20], Rn[19:16], list[15:0]. n = popcount(list).
- Lowest-address offset `base`: IA (P0 U1) 0; IB (P1 U1) +4; DA (P0 U0) 4-4n; DB (P1 U0) -4n.
- k-th register (0-based, ascending) transfers at off = base+4k. Emitted word: {cond, 2'b01, I=0, P=1, U=(off>=0), B=0, W=0, L, Rn, Rd=reg, imm12=|off|}. |off| ≤ 64.
- Registers are emitted in ascending order. Exception: if L=1 and Rn is in list, Rn's load is emitted last and keeps its own ascending-position offset.
- Writeback (W=1, and not (L=1 and Rn in list)): after transfers emit {cond, 2'b00, I=1, opcode U?4'b0100:4'b0010, S=0, Rn, Rd=Rn, rot=4'h0, imm8=4n}.
- Empty list: emit single {cond, 28'h1A00000} (MOV r0,r0) with out_last=1. No transfer, no writeback.
- Non-block words: emitted unchanged, out_last=1.
- out_user = S for transfer and writeback words of a block stream.
- States: IDLE (in_ready=1), XFER (emitting transfers; remaining-mask and k counter), WB (writeback word pending). IDLE→XFER on accepted block word with n>0; IDLE stays IDLE otherwise, with the output register loaded. XFER→WB after the last transfer is consumed if writeback is required, else →IDLE. WB→IDLE when consumed.

## Timing
- Reset: out_valid=0, out_code=0, out_last=0, out_user=0, busy=0, state IDLE. in_ready is 0 while rst=1.
- Output is registered. A word accepted in cycle N presents its first out_code at N+1.
- Throughput: one out word per cycle while out_ready=1. out_code, out_last and out_user stay stable while out_valid && !out_ready.
- in_ready = IDLE && (!out_valid || out_ready). A pass-through word may be accepted in the same cycle the previous last word is consumed.
- busy=1 from acceptance of a block word until its last word is consumed.
- flush: the next cycle has out_valid=0 and state IDLE. The input is not accepted in the flush cycle. Flush has priority over in_valid and out_ready.
- rst mid-stream: immediate return to reset values; no further words.

## Configuration
- LDM_EXPANDER_WB_EN defined: writeback words are generated as above.
- Not defined: W is ignored and no writeback word is ever emitted. The last transfer carries out_last. The WB state is not built.

## Test plan
- LDMIA r0!,{r1,r2} 0xE8B00006 -> 0xE5901000, 0xE5902004, 0xE2800008 (last), busy high 3 cycles.
- STMDB sp!,{r4,lr} 0xE92D4010 -> 0xE50D4008, 0xE50DE004, 0xE24DD008 (last).
- Pass-through 0xE0810002 back-to-back with out_ready=1 -> identical word every cycle, out_last=1, no bubbles.
- LDMIA r0!,{r0,r1} 0xE8B00003 -> 0xE5901004, 0xE5900000 (last), no writeback word.
- out_ready held low 3 cycles during the second word of test 1 -> 0xE5902004 held stable, then the stream completes. Flush issued during the first word of test 2 -> out_valid=0 next cycle, in_ready=1.
- Empty list 0xE8B00000 -> single 0xE1A00000, out_last=1. Without LDM_EXPANDER_WB_EN, test 1 -> two words, second with out_last=1.
